// File: rtl/bat_move_encoder.sv
// bat_move_encoder
//   Turns a rotary paddle (quadrature phases qa/qb) into a per-frame signed
//   bat delta for the game logic.
//   Input path: 2-FF synchronizer, then a debounce filter, then a quadrature
//   decoder, then a saturating accumulator.
//   On each frame strobe (the cycle after a vsync falling edge) the
//   accumulator is scaled into move and restarted.
//
// Ports
//   glb_clk : system clock
//   reset   : asynchronous, active-high reset
//   vsync   : game vertical sync, active-low, synchronous to glb_clk
//   qa, qb  : paddle quadrature phases, asynchronous
//   move    : signed 9-bit bat delta of the last frame (+ = bat up)
//   human   : high while a player is driving the paddle
//
// Parameters
//   DEBOUNCE    : cycles a synchronized level must hold before it is accepted
//   SCALE       : left shift (0..3) applied to the frame count
//   IDLE_FRAMES : consecutive zero-move frames before human is released
//
// Build option
//   PADDLE_AUTORELEASE_EN : when defined, an idle-frame counter releases
//   human. When undefined, human stays high until reset once it has been set.
module bat_move_encoder #(
    parameter int DEBOUNCE    = 4,
    parameter int SCALE       = 0,
    parameter int IDLE_FRAMES = 250
) (
    input  logic              glb_clk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              qa,
    input  logic              qb,
    output logic signed [8:0] move,
    output logic              human
);

    localparam int CNT_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);

    if (DEBOUNCE < 1 || SCALE < 0 || SCALE > 3 || IDLE_FRAMES < 1 || IDLE_FRAMES > 255) begin : g_bad_params
        $error("bat_move_encoder: parameter out of range");
    end

    // Bit 1 carries qa and bit 0 carries qb throughout.
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       prev_q;
    logic             prev_vld_q;
    logic             vsync_q, strobe_q;
    logic signed [8:0] acc_q, acc_d;
    logic signed [8:0] move_q, move_d;
    logic              human_q, human_d;
    logic signed [11:0] acc_ext;
    logic signed [8:0]  move_new;
    logic [1:0]         pos_delta;
    logic               step_up, step_dn;

    function automatic logic signed [8:0] sat9(input logic signed [11:0] v);
        if (v > 12'sd255)
            return 9'sd255;
        else if (v < -12'sd256)
            return 9'sh100;
        else
            return v[8:0];
    endfunction

    function automatic logic signed [8:0] acc_step(input logic signed [8:0] a,
                                                   input logic up, input logic dn);
        if (up && a != 9'sd255)
            return a + 9'sd1;
        if (dn && a != 9'sh100)
            return a - 9'sd1;
        return a;
    endfunction

    // Gray position 00,01,11,10 -> 0,1,2,3 so that a move is a modulo-4 difference.
    function automatic logic [1:0] gray_pos(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    always_ff @(posedge glb_clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {qa, qb};
            sync2_q <= sync1_q;
        end
    end

    // A filtered bit follows its synchronized level only after DEBOUNCE
    // consecutive cycles of disagreement; any agreement restarts the count.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE - 1))
                    filt_d[i] = sync2_q[i];
                else
                    cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge glb_clk or posedge reset) begin
        if (reset) begin
            filt_q <= 2'b00;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // A difference of 2 is a double transition and counts nothing.
    assign pos_delta = gray_pos(filt_q) - gray_pos(prev_q);
    assign step_up   = prev_vld_q && (pos_delta == 2'd1);
    assign step_dn   = prev_vld_q && (pos_delta == 2'd3);

    assign acc_ext  = 12'(acc_q) <<< SCALE;
    assign move_new = sat9(acc_ext);

    always_comb begin
        acc_d   = acc_step(acc_q, step_up, step_dn);
        move_d  = move_q;
        human_d = human_q | step_up | step_dn;
        if (strobe_q) begin
            // A step decoded on the strobe cycle opens the new frame.
            move_d = move_new;
            acc_d  = step_up ? 9'sd1 : (step_dn ? -9'sd1 : 9'sd0);
        end
    end

`ifdef PADDLE_AUTORELEASE_EN
    localparam logic [7:0] IDLE_LIM = 8'(IDLE_FRAMES);
    logic [7:0] idle_q, idle_d;
    logic       human_rel;

    always_comb begin
        idle_d    = idle_q;
        human_rel = 1'b0;
        if (strobe_q) begin
            if (move_new != 9'sd0 || step_up || step_dn) begin
                idle_d = 8'd0;
            end else begin
                if (idle_q != 8'hFF)
                    idle_d = idle_q + 8'd1;
                human_rel = (idle_d >= IDLE_LIM);
            end
        end
    end

    always_ff @(posedge glb_clk or posedge reset) begin
        if (reset)
            idle_q <= 8'd0;
        else
            idle_q <= idle_d;
    end
`else
    logic human_rel;
    assign human_rel = 1'b0;
`endif

    // vsync_q clears on reset so an edge in the release cycle cannot strobe;
    // prev_vld_q makes the first filtered sample seed the decoder.
    always_ff @(posedge glb_clk or posedge reset) begin
        if (reset) begin
            prev_q     <= 2'b00;
            prev_vld_q <= 1'b0;
            vsync_q    <= 1'b0;
            strobe_q   <= 1'b0;
            acc_q      <= '0;
            move_q     <= '0;
            human_q    <= 1'b0;
        end else begin
            prev_q     <= filt_q;
            prev_vld_q <= 1'b1;
            vsync_q    <= vsync;
            strobe_q   <= vsync_q & ~vsync;
            acc_q      <= acc_d;
            move_q     <= move_d;
            human_q    <= human_d & ~human_rel;
        end
    end

    assign move  = move_q;
    assign human = human_q;

endmodule

// File: tb/tb_bat_move_encoder.sv
`timescale 1ns/1ps
module tb_bat_move_encoder;
    localparam int DEB  = 4;
    localparam int IDLE = 3;
    localparam int HOLD = DEB + 5;

    logic clk = 1'b0;
    logic reset, vsync, qa, qb;
    logic signed [8:0] move0, move2;
    logic human0, human2;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // reference model state
    int pos;
    int m_acc;
    int m_idle;
    bit m_human;
    logic signed [8:0] m_mv0, m_mv2;

    always #5 clk = ~clk;

    bat_move_encoder #(.DEBOUNCE(DEB), .SCALE(0), .IDLE_FRAMES(IDLE)) u_dut_s0 (
        .glb_clk(clk), .reset(reset), .vsync(vsync), .qa(qa), .qb(qb),
        .move(move0), .human(human0));

    bat_move_encoder #(.DEBOUNCE(DEB), .SCALE(2), .IDLE_FRAMES(IDLE)) u_dut_s2 (
        .glb_clk(clk), .reset(reset), .vsync(vsync), .qa(qa), .qb(qb),
        .move(move2), .human(human2));

    function automatic int clampi(int v);
        if (v > 255) return 255;
        if (v < -256) return -256;
        return v;
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_pos();
        case (pos & 3)
            0: {qa, qb} = 2'b00;
            1: {qa, qb} = 2'b01;
            2: {qa, qb} = 2'b11;
            default: {qa, qb} = 2'b10;
        endcase
    endtask

    task automatic do_step(int dir);
        pos = (pos + dir) & 3;
        drive_pos();
        tick(HOLD);
        m_acc   = clampi(m_acc + dir);
        m_human = 1'b1;
    endtask

    // Frame boundary in the model; carry is a step credited to the new frame.
    task automatic model_strobe(int carry);
        m_mv0 = 9'(clampi(m_acc));
        m_mv2 = 9'(clampi(m_acc * 4));
        if (m_mv0 != 0 || carry != 0) m_idle = 0;
        else if (m_idle < 255) m_idle++;
`ifdef PADDLE_AUTORELEASE_EN
        if (m_mv0 == 0 && carry == 0 && m_idle >= IDLE) m_human = 1'b0;
`endif
        m_acc = carry;
        if (carry != 0) m_human = 1'b1;
    endtask

    task automatic frame_end();
        vsync = 1'b0;
        tick(3);
        vsync = 1'b1;
        tick(4);
        model_strobe(0);
    endtask

    task automatic test_reset();
        reset = 1'b1; vsync = 1'b1;
        pos = 2; drive_pos();            // paddle resting at 11
        m_acc = 0; m_idle = 0; m_human = 1'b0;
        tick(3);
        chk_cnt++; if (move0 !== 9'sd0) $display("FAIL reset_move_s0 got %0d want 0", move0); else pass_cnt++;
        chk_cnt++; if (move2 !== 9'sd0) $display("FAIL reset_move_s2 got %0d want 0", move2); else pass_cnt++;
        chk_cnt++; if (human0 !== 1'b0) $display("FAIL reset_human got %b want 0", human0); else pass_cnt++;
        reset = 1'b0;
        tick(12);
        chk_cnt++; if (human0 !== 1'b0) $display("FAIL rest11_no_step_human got %b want 0", human0); else pass_cnt++;
        frame_end();
        chk_cnt++; if (move0 !== m_mv0) $display("FAIL rest11_move got %0d want %0d", move0, m_mv0); else pass_cnt++;
    endtask

    task automatic test_forward();
        do_step(1);
        chk_cnt++; if (human0 !== 1'b1) $display("FAIL fwd_human_set got %b want 1", human0); else pass_cnt++;
        for (int i = 1; i < 40; i++) do_step(1);
        frame_end();
        chk_cnt++; if (move0 !== m_mv0 || m_mv0 !== 9'sd40) $display("FAIL fwd_move_s0 got %0d want %0d", move0, m_mv0); else pass_cnt++;
        chk_cnt++; if (move2 !== m_mv2) $display("FAIL fwd_move_s2 got %0d want %0d", move2, m_mv2); else pass_cnt++;
        frame_end();
        chk_cnt++; if (move0 !== 9'sd0) $display("FAIL fwd_next_frame got %0d want 0", move0); else pass_cnt++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) do_step(-1);
        frame_end();
        chk_cnt++; if (move0 !== m_mv0 || m_mv0 !== 9'sh100) $display("FAIL sat_neg_s0 got %0d want %0d", move0, m_mv0); else pass_cnt++;
        chk_cnt++; if (move2 !== m_mv2) $display("FAIL sat_neg_s2 got %0d want %0d", move2, m_mv2); else pass_cnt++;
        for (int i = 0; i < 100; i++) do_step(1);
        frame_end();
        chk_cnt++; if (move0 !== m_mv0) $display("FAIL sat_pos_s0 got %0d want %0d", move0, m_mv0); else pass_cnt++;
        chk_cnt++; if (move2 !== m_mv2 || m_mv2 !== 9'sd255) $display("FAIL sat_pos_s2 got %0d want %0d", move2, m_mv2); else pass_cnt++;
    endtask

    task automatic test_glitch();
        qa = ~qa;
        tick(2);
        qa = ~qa;
        tick(12);
        pos = (pos + 2) & 3;             // both phases flip at once
        drive_pos();
        tick(12);
        frame_end();
        chk_cnt++; if (move0 !== 9'sd0) $display("FAIL glitch_double_move got %0d want 0", move0); else pass_cnt++;
        chk_cnt++; if (move2 !== 9'sd0) $display("FAIL glitch_double_move_s2 got %0d want 0", move2); else pass_cnt++;
    endtask

    task automatic test_strobe_step();
        for (int i = 0; i < 5; i++) do_step(1);
        pos = (pos + 1) & 3;
        drive_pos();
        // the decoded step lands exactly on the strobe cycle
        tick(DEB + 1);
        vsync = 1'b0;
        model_strobe(1);
        tick(3);
        vsync = 1'b1;
        tick(4);
        chk_cnt++; if (move0 !== m_mv0 || m_mv0 !== 9'sd5) $display("FAIL strobe_step_move got %0d want %0d", move0, m_mv0); else pass_cnt++;
        chk_cnt++; if (move2 !== m_mv2) $display("FAIL strobe_step_move_s2 got %0d want %0d", move2, m_mv2); else pass_cnt++;
        frame_end();
        chk_cnt++; if (move0 !== m_mv0 || m_mv0 !== 9'sd1) $display("FAIL strobe_step_carry got %0d want %0d", move0, m_mv0); else pass_cnt++;
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            int n;
            n = $urandom_range(0, 15);
            for (int i = 0; i < n; i++) do_step(($urandom_range(0, 1) == 1) ? 1 : -1);
            frame_end();
            chk_cnt++; if (move0 !== m_mv0) $display("FAIL rand_move_s0 f%0d got %0d want %0d", f, move0, m_mv0); else pass_cnt++;
            chk_cnt++; if (move2 !== m_mv2) $display("FAIL rand_move_s2 f%0d got %0d want %0d", f, move2, m_mv2); else pass_cnt++;
            chk_cnt++; if (human0 !== m_human) $display("FAIL rand_human f%0d got %b want %b", f, human0, m_human); else pass_cnt++;
        end
    endtask

    task automatic test_idle();
        do_step(1);
        frame_end();
        chk_cnt++; if (human0 !== 1'b1) $display("FAIL idle_start_human got %b want 1", human0); else pass_cnt++;
        for (int f = 1; f <= 4; f++) begin
            frame_end();
            chk_cnt++; if (human0 !== m_human) $display("FAIL idle_human_s0 f%0d got %b want %b", f, human0, m_human); else pass_cnt++;
            chk_cnt++; if (human2 !== m_human) $display("FAIL idle_human_s2 f%0d got %b want %b", f, human2, m_human); else pass_cnt++;
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 5; i++) do_step(-1);
        frame_end();
        chk_cnt++; if (move0 !== m_mv0) $display("FAIL pre_reset_move got %0d want %0d", move0, m_mv0); else pass_cnt++;
        for (int i = 0; i < 17; i++) do_step(1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        m_acc = 0; m_idle = 0; m_human = 1'b0;
        chk_cnt++; if (move0 !== 9'sd0) $display("FAIL async_reset_move_s0 got %0d want 0", move0); else pass_cnt++;
        chk_cnt++; if (move2 !== 9'sd0) $display("FAIL async_reset_move_s2 got %0d want 0", move2); else pass_cnt++;
        chk_cnt++; if (human0 !== 1'b0) $display("FAIL async_reset_human got %b want 0", human0); else pass_cnt++;
        pos = 0; drive_pos();
        tick(3);
        reset = 1'b0;
        tick(12);
        frame_end();
        chk_cnt++; if (move0 !== m_mv0 || m_mv0 !== 9'sd0) $display("FAIL post_reset_move got %0d want %0d", move0, m_mv0); else pass_cnt++;
        chk_cnt++; if (human0 !== 1'b0) $display("FAIL post_reset_human got %b want 0", human0); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_saturation();
        test_glitch();
        test_strobe_step();
        test_random();
        test_idle();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout simulation exceeded 2ms");
        $fatal(1, "timeout");
    end

endmodule
